// File: rtl/part_3_operand_loader.sv
// Byte-serial operand loader: assembles two little-endian 32-bit operands and presents them as a pair.
// Optional partial-frame timeout is enabled with `define PART_3_TIMEOUT_EN.
module part_3_operand_loader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err
);

  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] sh_a_q, sh_a_d;
  logic [31:0] sh_b_q, sh_b_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        out_valid_q, out_valid_d;
  logic        ready_q, ready_d;
  logic        accept;

  assign accept    = in_valid & ready_q;
  assign in_ready  = ready_q;
  assign a         = a_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;

`ifdef PART_3_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          sh_a_d[{idx_q, 3'b000} +: 8] = in_data;
          if (idx_q == 2'd3) begin
            state_d = LOAD_B;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          sh_b_d[{idx_q, 3'b000} +: 8] = in_data;
          if (idx_q == 2'd3) begin
            // Both operands become visible on the same edge as the final byte.
            a_d         = sh_a_q;
            b_d         = {in_data, sh_b_q[23:0]};
            out_valid_d = 1'b1;
            state_d     = PRESENT;
            idx_d       = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      PRESENT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD_A;
          idx_d       = 2'd0;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = 2'd0;
      end
    endcase

`ifdef PART_3_TIMEOUT_EN
    tmo_d       = '0;
    frame_err_d = 1'b0;
    // An accepted byte always wins over an expiring timer.
    if (!accept && ((state_q == LOAD_A && idx_q != 2'd0) || state_q == LOAD_B)) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = LOAD_A;
        idx_d       = 2'd0;
        sh_a_d      = '0;
        sh_b_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    ready_d = (state_d != PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      idx_q       <= 2'd0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

`ifdef PART_3_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_part_3_operand_loader.sv
// Self-checking bench for part_3_operand_loader: vector table plus hand-written corner sequences.
// Timeout sequences are built only when PART_3_TIMEOUT_EN is defined.
module tb_part_3_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_err;

  part_3_operand_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  by [8];
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs [5];
  int          n_vec = 0;
  int          n_err = 0;
  int          err_pulses = 0;
  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one byte after `gap` idle cycles; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_present(input string tag);
    exp_t e;
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_a"}, a, e.ea);
      chk({tag, "_b"}, b, e.eb);
      model_a = e.ea;
      model_b = e.eb;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_cons_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_cons_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_cons_a"}, a, model_a);
    chk({tag, "_cons_b"}, b, model_b);
  endtask

  task automatic load_frame(input vec_t v, input int gap, input string tag);
    exp_t e;
    e.ea = v.ea;
    e.eb = v.eb;
    sb_q.push_back(e);
    for (int i = 0; i < 8; i++) send_byte(v.by[i], gap);
    check_present(tag);
  endtask

  initial begin
    vec_t v;
    int   p0;

    vecs[0].by = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    vecs[0].ea = 32'h0000_0001; vecs[0].eb = 32'h0000_0002;
    vecs[1].by = '{8'hff, 8'hff, 8'h00, 8'h00, 8'hc1, 8'hcc, 8'h02, 8'h00};
    vecs[1].ea = 32'h0000_ffff; vecs[1].eb = 32'h0002_ccc1;
    vecs[2].by = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hef, 8'hcd, 8'hab, 8'h89};
    vecs[2].ea = 32'h1234_5678; vecs[2].eb = 32'h89ab_cdef;
    vecs[3].by = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].ea = 32'h0000_0000; vecs[3].eb = 32'h0000_0000;
    vecs[4].by = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
    vecs[4].ea = 32'hffff_ffff; vecs[4].eb = 32'hffff_ffff;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel_in_ready_post_edge", {31'd0, in_ready}, 32'd1);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      load_frame(vecs[i], 0, $sformatf("vec%0d", i));
      consume($sformatf("vec%0d", i));
    end

    // Backpressure with junk bytes offered while presenting
    load_frame(vecs[2], 0, "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'haa;
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_a", c), a, model_a);
      chk($sformatf("bp_hold%0d_b", c), b, model_b);
    end
    in_valid = 1'b0;
    consume("bp");
    load_frame(vecs[0], 0, "after_bp");
    consume("after_bp");

    // Gaps of 3 idle cycles between every byte
    v.by = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    v.ea = 32'd1; v.eb = 32'd1;
    p0 = err_pulses;
    load_frame(v, 3, "gap");
    consume("gap");
    chk("gap_no_frame_err", err_pulses, p0);

`ifdef PART_3_TIMEOUT_EN
    // 3 bytes then 16 idle cycles: abort with a single one-cycle pulse
    p0 = err_pulses;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    repeat (18) @(negedge clk);
    chk("tmo_pulses", err_pulses, p0 + 1);
    chk("tmo_a_kept", a, model_a);
    chk("tmo_b_kept", b, model_b);
    v.by = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
    v.ea = 32'd5; v.eb = 32'd6;
    load_frame(v, 0, "tmo_next");
    consume("tmo_next");
    // Byte accepted on the very cycle the limit would be reached
    p0 = err_pulses;
    v.by = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    v.ea = 32'h1122_3344; v.eb = 32'h5566_7788;
    sb_q.push_back('{ea: v.ea, eb: v.eb});
    send_byte(v.by[0], 0);
    send_byte(v.by[1], 15);
    for (int i = 2; i < 8; i++) send_byte(v.by[i], 0);
    check_present("tmo_edge");
    consume("tmo_edge");
    chk("tmo_edge_no_err", err_pulses, p0);
    // No timeout while idle in LOAD_A with index 0 or in PRESENT
    p0 = err_pulses;
    repeat (40) @(negedge clk);
    load_frame(vecs[2], 0, "tmo_present");
    repeat (40) @(negedge clk);
    chk("tmo_present_valid", {31'd0, out_valid}, 32'd1);
    consume("tmo_present");
    chk("tmo_idle_no_err", err_pulses, p0);
`else
    // Without the timeout a partial frame waits indefinitely
    p0 = err_pulses;
    sb_q.push_back('{ea: vecs[2].ea, eb: vecs[2].eb});
    for (int i = 0; i < 3; i++) send_byte(vecs[2].by[i], 0);
    repeat (40) @(negedge clk);
    for (int i = 3; i < 8; i++) send_byte(vecs[2].by[i], 0);
    check_present("notmo");
    consume("notmo");
    chk("notmo_no_frame_err", err_pulses, p0);
`endif

    // Reset mid-frame after 5 bytes
    for (int i = 0; i < 5; i++) send_byte(vecs[4].by[i], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a", a, 32'd0);
    chk("mid_rst_b", b, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    model_a = '0;
    model_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_frame(vecs[2], 0, "post_rst");
    consume("post_rst");

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/part_3_operand_loader.md
PART_3_OPERAND_LOADER -- requirements
Module: part_3_operand_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: idle cycles inside a partial frame before abort; used only with PART_3_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  8  operand byte from upstream.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-007 SHALL have port a  output  32  operand A to the downstream 32-bit adder.
REQ-008 SHALL have port b  output  32  operand B to the downstream 32-bit adder.
REQ-009 SHALL have port out_valid  output  1  a and b hold a complete operand pair.
REQ-010 SHALL have port out_ready  input  1  downstream consumed the pair.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-012 SHALL implement states LOAD_A, LOAD_B and PRESENT, plus a 2-bit byte index.
REQ-013 SHALL accept a byte on a rising clk edge when in_valid and in_ready are both 1.
REQ-014 SHALL drive in_ready=1 in LOAD_A and LOAD_B, and in_ready=0 in PRESENT.
REQ-015 SHALL assemble each operand little-endian: byte index k goes to bits [8k+7:8k] of an internal shadow register.
REQ-016 SHALL move LOAD_A to LOAD_B, with index cleared, on acceptance of byte index 3.
REQ-017 SHALL, on acceptance of byte index 3 in LOAD_B, load both shadows into a and b on the same edge, enter PRESENT and set out_valid=1.
  - out_valid is high the cycle after the 8th accepted byte.
REQ-018 SHALL hold a, b and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on an edge with out_valid and out_ready both 1, clear out_valid, enter LOAD_A with index 0, and keep a and b unchanged.
REQ-020 SHALL change a and b only at frame completion; partial frames are never visible on a or b.
REQ-021 SHALL tolerate in_valid gaps of any length between bytes without corrupting the frame (timeout excepted, REQ-026).
REQ-022 SHALL ignore in_data whenever in_valid=0 or in_ready=0.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force: a=0, b=0, out_valid=0, frame_err=0, in_ready=0, state LOAD_A, index 0, shadows 0, timeout counter 0.
REQ-024 SHALL assert in_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-025 SHALL, on reset mid-frame or in PRESENT, discard all partial and presented data.

Configuration
REQ-026 SHALL, with PART_3_TIMEOUT_EN defined, apply a frame timeout:
  - count consecutive cycles with no accepted byte while in LOAD_A with index>0, or in LOAD_B;
  - clear the counter on every accepted byte;
  - when the count reaches TIMEOUT_CYCLES, discard the shadows, return to LOAD_A with index 0, and pulse frame_err for exactly 1 cycle;
  - never time out in LOAD_A with index 0, or in PRESENT;
  - if a byte is accepted in the cycle the limit would be reached, accept the byte and do not abort;
  - leave a and b unchanged on abort.
REQ-027 SHALL, without PART_3_TIMEOUT_EN, contain no timeout counter, tie frame_err to 0, and wait indefinitely for bytes.

Verification
REQ-028 SHALL cover basic load: bytes 01 00 00 00 02 00 00 00, out_ready=1 -> a=00000001, b=00000002, out_valid high 1 cycle after 8th byte.
REQ-029 SHALL cover byte order: bytes ff ff 00 00 c1 cc 02 00 -> a=0000ffff, b=0002ccc1.
REQ-030 SHALL cover backpressure: complete frame, out_ready=0 for 5 cycles -> out_valid, a, b held, in_ready=0; out_ready=1 -> out_valid=0, in_ready=1 next cycle, a and b unchanged.
REQ-031 SHALL cover in_valid gaps: 3-cycle gaps between every byte of frame 01 00 00 00 01 00 00 00 -> a=1, b=1; with PART_3_TIMEOUT_EN and TIMEOUT_CYCLES=16, no frame_err.
REQ-032 SHALL cover timeout (PART_3_TIMEOUT_EN): 3 bytes then 16 idle cycles -> one frame_err pulse, a and b unchanged; next full frame 05 00 00 00 06 00 00 00 -> a=5, b=6.
REQ-033 SHALL cover reset mid-operation: rst_n low after 5 bytes -> all outputs 0 immediately; new frame after release loads correctly.
